// File: rtl/plru_pkg.sv
// Tree pseudo-LRU types and helpers shared by plru_tree and its victim walk.
// Trees are sized by PLRU_ASSOC; the top's ASSOCIATIVITY must match it.
package plru_pkg;

    localparam int PLRU_ASSOC  = 8;
    localparam int PLRU_LEVELS = $clog2(PLRU_ASSOC);

    typedef logic [PLRU_ASSOC-2:0]  tree_bits_t;
    typedef logic [PLRU_ASSOC-1:0]  way_mask_t;
    typedef logic [PLRU_LEVELS-1:0] way_idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } flush_state_e;

    // 1 when every way in [base, base+size) is locked.
    function automatic logic range_locked(way_mask_t lock, int base, int size);
        logic      full;
        way_mask_t sh;
        full = 1'b1;
        for (int i = 0; i < PLRU_ASSOC; i++) begin
            sh = lock >> i;
            if (i >= base && i < base + size && !sh[0]) begin
                full = 1'b0;
            end
        end
        return full;
    endfunction

    function automatic way_idx_t plru_victim(tree_bits_t tree, way_mask_t lock = '0);
        int         node;
        int         lo;
        int         half;
        logic       right;
        logic       every;
        tree_bits_t sh;
        node  = 0;
        lo    = 0;
        half  = PLRU_ASSOC;
        every = &lock;
        for (int lvl = 0; lvl < PLRU_LEVELS; lvl++) begin
            half  = half / 2;
            sh    = tree >> node;
            right = sh[0];
            // A fully locked build falls back to the plain tree choice.
            if (!every) begin
                if (right && range_locked(lock, lo + half, half)) begin
                    right = 1'b0;
                end else if (!right && range_locked(lock, lo, half)) begin
                    right = 1'b1;
                end
            end
            if (right) begin
                lo   = lo + half;
                node = 2 * node + 2;
            end else begin
                node = 2 * node + 1;
            end
        end
        return way_idx_t'(lo);
    endfunction

    function automatic tree_bits_t plru_touch(tree_bits_t tree, way_idx_t way);
        tree_bits_t t;
        way_idx_t   w;
        int         node;
        logic       go_right;
        t    = tree;
        node = 0;
        for (int lvl = 0; lvl < PLRU_LEVELS; lvl++) begin
            w        = way >> (PLRU_LEVELS - 1 - lvl);
            go_right = w[0];
            t = (t & ~(tree_bits_t'(1) << node)) | (tree_bits_t'(!go_right) << node);
            node = go_right ? (2 * node + 2) : (2 * node + 1);
        end
        return t;
    endfunction

endpackage

// File: rtl/plru_tree_node_walk.sv
// Combinational root-to-leaf victim walk of one PLRU tree.
// With PLRU_LOCK_EN defined, a way lock mask steers the walk away from locked subtrees.
module plru_tree_node_walk
    import plru_pkg::*;
(
    input  tree_bits_t tree,
`ifdef PLRU_LOCK_EN
    input  way_mask_t  way_lock,
    output logic       all_locked,
`endif
    output way_idx_t   victim
);

`ifdef PLRU_LOCK_EN
    assign victim     = plru_victim(tree, way_lock);
    assign all_locked = &way_lock;
`else
    assign victim     = plru_victim(tree);
`endif

endmodule

// File: rtl/plru_tree.sv
// Per-set tree pseudo-LRU tracker: registered victim lookup, update bypass, flush sweep.
// Optional way locking is compiled in with PLRU_LOCK_EN.
//
//  state | meaning
//  IDLE  | lookups and updates serviced normally
//  FLUSH | one set cleared per cycle, updates dropped, lru_way held at 0
module plru_tree
    import plru_pkg::*;
#(
    parameter int ASSOCIATIVITY = PLRU_ASSOC,
    parameter int ENTRIES       = 256,
    parameter int INDEX_BITS    = $clog2(ENTRIES),
    parameter int OUTPUT_BITS   = $clog2(ASSOCIATIVITY)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_BITS-1:0]  line_selector,
    output logic [OUTPUT_BITS-1:0] lru_way,
    input  logic                   lru_update,
    input  logic [INDEX_BITS-1:0]  update_index,
    input  logic [OUTPUT_BITS-1:0] referenced_set,
    input  logic                   flush_req,
    output logic                   flush_busy,
    output logic                   flush_done
`ifdef PLRU_LOCK_EN
    ,
    input  logic [ASSOCIATIVITY-1:0] way_lock,
    output logic                     all_locked
`endif
);

    localparam logic [INDEX_BITS-1:0] LAST_SET   = INDEX_BITS'(ENTRIES - 1);
    localparam logic [INDEX_BITS-1:0] PENULT_SET = INDEX_BITS'(ENTRIES - 2);

    tree_bits_t            tree_mem [ENTRIES];
    flush_state_e          state;
    logic [INDEX_BITS-1:0] flush_cnt;
    way_idx_t              lru_way_q;
    way_idx_t              walk_way;
    tree_bits_t            rd_tree;
    tree_bits_t            upd_tree;
    logic                  upd_en;

    assign upd_en   = lru_update && (state == IDLE);
    assign upd_tree = plru_touch(tree_mem[update_index], way_idx_t'(referenced_set));

    // Lookup sees the tree as it will be after this edge's write.
    always_comb begin
        rd_tree = tree_mem[line_selector];
        if (state == FLUSH && line_selector <= flush_cnt) begin
            rd_tree = '0;
        end else if (upd_en && update_index == line_selector) begin
            rd_tree = upd_tree;
        end
    end

`ifdef PLRU_LOCK_EN
    logic walk_all_locked;

    plru_tree_node_walk u_walk (
        .tree       (rd_tree),
        .way_lock   (way_mask_t'(way_lock)),
        .all_locked (walk_all_locked),
        .victim     (walk_way)
    );
`else
    plru_tree_node_walk u_walk (
        .tree   (rd_tree),
        .victim (walk_way)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tree_mem[i] <= '0;
            end
            state      <= IDLE;
            flush_cnt  <= '0;
            flush_busy <= 1'b0;
            flush_done <= 1'b0;
            lru_way_q  <= '0;
`ifdef PLRU_LOCK_EN
            all_locked <= 1'b0;
`endif
        end else begin
            flush_done <= 1'b0;
            lru_way_q  <= walk_way;
`ifdef PLRU_LOCK_EN
            all_locked <= walk_all_locked;
`endif
            case (state)
                IDLE: begin
                    if (upd_en) begin
                        tree_mem[update_index] <= upd_tree;
                    end
                    if (flush_req) begin
                        state      <= FLUSH;
                        flush_busy <= 1'b1;
                        flush_cnt  <= '0;
                    end
                end
                FLUSH: begin
                    tree_mem[flush_cnt] <= '0;
                    if (flush_cnt == LAST_SET) begin
                        state      <= IDLE;
                        flush_busy <= 1'b0;
                        flush_cnt  <= '0;
                    end else begin
                        flush_cnt  <= flush_cnt + INDEX_BITS'(1);
                        flush_done <= (flush_cnt == PENULT_SET);
                    end
                end
                default: begin
                    state      <= IDLE;
                    flush_busy <= 1'b0;
                end
            endcase
        end
    end

    assign lru_way = flush_busy ? '0 : OUTPUT_BITS'(lru_way_q);

endmodule

// File: tb/tb_plru_tree.sv
// Self-checking bench for plru_tree (ASSOCIATIVITY=8, ENTRIES=16) against a heap-index PLRU model.
module tb_plru_tree;

    localparam int A = 8;
    localparam int L = 3;
    localparam int E = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] line_selector;
    logic [3:0] update_index;
    logic [2:0] lru_way;
    logic [2:0] referenced_set;
    logic       lru_update;
    logic       flush_req;
    logic       flush_busy;
    logic       flush_done;
`ifdef PLRU_LOCK_EN
    logic [7:0] way_lock;
    logic       all_locked;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int mdl [E];

    always #5 clk = ~clk;

    plru_tree #(.ASSOCIATIVITY(A), .ENTRIES(E)) dut (
        .clk            (clk),
        .rst            (rst),
        .line_selector  (line_selector),
        .lru_way        (lru_way),
        .lru_update     (lru_update),
        .update_index   (update_index),
        .referenced_set (referenced_set),
        .flush_req      (flush_req),
        .flush_busy     (flush_busy),
        .flush_done     (flush_done)
`ifdef PLRU_LOCK_EN
        ,
        .way_lock       (way_lock),
        .all_locked     (all_locked)
`endif
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int lock_now();
`ifdef PLRU_LOCK_EN
        return int'(way_lock);
`else
        return 0;
`endif
    endfunction

    // Node on the path to way w at depth lvl, in heap numbering.
    function automatic int node_of(input int lvl, input int w);
        return (1 << lvl) - 1 + (w >> (L - lvl));
    endfunction

    function automatic void mdl_touch(input int s, input int w);
        for (int l = 0; l < L; l++) begin
            int n;
            n = node_of(l, w);
            if (((w >> (L - 1 - l)) & 1) != 0) mdl[s] = mdl[s] & ~(1 << n);
            else                               mdl[s] = mdl[s] | (1 << n);
        end
    endfunction

    function automatic bit range_full(input int lk, input int base, input int n);
        for (int i = base; i < base + n; i++) begin
            if (((lk >> i) & 1) == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int mdl_victim(input int t, input int lk);
        int lo;
        int half;
        bit right;
        bit all;
        lo  = 0;
        all = (lk == (1 << A) - 1);
        for (int l = 0; l < L; l++) begin
            half  = A >> (l + 1);
            right = ((t >> node_of(l, lo)) & 1) != 0;
            if (!all) begin
                if (right && range_full(lk, lo + half, half)) right = 1'b0;
                else if (!right && range_full(lk, lo, half)) right = 1'b1;
            end
            if (right) lo += half;
        end
        return lo;
    endfunction

    function automatic void mdl_clear();
        for (int e = 0; e < E; e++) mdl[e] = 0;
    endfunction

    // One normal-mode cycle: model follows the sampled inputs, then outputs are checked.
    task automatic step(input string tag);
        int exp_w;
        int lk;
        @(posedge clk);
        lk = lock_now();
        if (lru_update) mdl_touch(int'(update_index), int'(referenced_set));
        exp_w = mdl_victim(mdl[int'(line_selector)], lk);
        #1;
        check(tag, int'(lru_way), exp_w);
`ifdef PLRU_LOCK_EN
        check({tag, "_all_locked"}, int'(all_locked), int'(lk == 255));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seq [4];
        int dones;
        seq = '{0, 4, 2, 6};
        rst = 1'b1;
        line_selector = '0; update_index = '0; referenced_set = '0;
        lru_update = 1'b0; flush_req = 1'b0;
`ifdef PLRU_LOCK_EN
        way_lock = '0;
`endif
        mdl_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(flush_busy), 0);
        check("rst_done", int'(flush_done), 0);
        check("rst_way", int'(lru_way), 0);
        rst = 1'b0;

        line_selector = 4'd5;
        step("reset_set5");

        line_selector = 4'd3; update_index = 4'd3; lru_update = 1'b1;
        for (int i = 0; i < 4; i++) begin
            referenced_set = 3'(seq[i]);
            step("touch_set3");
        end
        lru_update = 1'b0;
        step("set3_hold");
        check("set3_victim1", int'(lru_way), 1);
        lru_update = 1'b1; referenced_set = 3'd1;
        step("set3_touch1");
        check("set3_victim5", int'(lru_way), 5);

        line_selector = 4'd7; update_index = 4'd7; referenced_set = 3'd0;
        step("bypass7");
        check("bypass7_way4", int'(lru_way), 4);
        lru_update = 1'b0;

        for (int i = 0; i < 400; i++) begin
            line_selector  = 4'($urandom_range(0, E - 1));
            lru_update     = 1'($urandom_range(0, 1));
            update_index   = ($urandom_range(0, 2) == 0) ? line_selector : 4'($urandom_range(0, E - 1));
            referenced_set = 3'($urandom_range(0, A - 1));
`ifdef PLRU_LOCK_EN
            case ($urandom_range(0, 3))
                0:       way_lock = 8'hFF;
                1:       way_lock = 8'h00;
                default: way_lock = 8'($urandom);
            endcase
`endif
            step("rand");
        end
`ifdef PLRU_LOCK_EN
        way_lock = '0;
`endif

        // Flush after dirtying the first and last sets.
        lru_update = 1'b1;
        update_index = 4'd0; referenced_set = 3'd3; line_selector = 4'd0;
        step("dirty0");
        update_index = 4'd15; referenced_set = 3'd6; line_selector = 4'd15;
        step("dirty15");
        lru_update = 1'b0;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        for (int k = 1; k <= E; k++) begin
            check("flush_busy", int'(flush_busy), 1);
            check("flush_done", int'(flush_done), int'(k == E));
            check("flush_way0", int'(lru_way), 0);
            line_selector = 4'(k - 1);
            if (k == 4) begin
                lru_update = 1'b1; update_index = 4'd0; referenced_set = 3'd0; flush_req = 1'b1;
            end else begin
                lru_update = 1'b0; flush_req = 1'b0;
            end
            tick();
        end
        mdl_clear();
        check("flush_end_busy", int'(flush_busy), 0);
        check("flush_end_done", int'(flush_done), 0);
        check("flush_end_way", int'(lru_way), mdl_victim(mdl[15], lock_now()));
        for (int s = 0; s < E; s++) begin
            line_selector = 4'(s);
            step("post_flush_sweep");
        end

        // Reset in the middle of a flush.
        lru_update = 1'b1;
        update_index = 4'd2; referenced_set = 3'd5;
        step("dirty2");
        update_index = 4'd10; referenced_set = 3'd1;
        step("dirty10");
        lru_update = 1'b0;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check("midrst_busy", int'(flush_busy), 0);
        check("midrst_done", int'(flush_done), 0);
        check("midrst_way", int'(lru_way), 0);
        #1;
        rst = 1'b0;
        mdl_clear();
        for (int s = 0; s < E; s++) begin
            line_selector = 4'(s);
            step("post_rst_sweep");
        end
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        check("reflush_busy", int'(flush_busy), 1);
        dones = 0;
        for (int k = 1; k <= E; k++) begin
            if (flush_done) dones++;
            tick();
        end
        check("reflush_end_busy", int'(flush_busy), 0);
        check("reflush_done_pulses", dones, 1);

`ifdef PLRU_LOCK_EN
        line_selector = 4'd4;
        way_lock = 8'h0F;
        step("lock_0f");
        check("lock_0f_way4", int'(lru_way), 4);
        way_lock = 8'hFF;
        step("lock_ff");
        check("lock_ff_way0", int'(lru_way), 0);
        check("lock_ff_all", int'(all_locked), 1);
        way_lock = '0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
